// File: rtl/nios_system_iic_pkg.sv
// Shared types and constants for the byte-level I2C master: FSM states,
// Avalon register map, CMD/STATUS bit positions, quarter-phase encodings.
package nios_system_iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CMD     = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_DIVIDER = 2'd3;

    localparam int unsigned CMD_START  = 0;
    localparam int unsigned CMD_STOP   = 1;
    localparam int unsigned CMD_WR     = 2;
    localparam int unsigned CMD_RD     = 3;
    localparam int unsigned CMD_ACKVAL = 4;

    localparam int unsigned STAT_NACK = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_IEN  = 2;
    localparam int unsigned STAT_BUSY = 3;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // {sda_oe, scl_oe} for a state/phase; IDLE keeps the bus as it was left
    function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph,
                                              logic bit_oe, logic [1:0] idle_oe);
        logic [1:0] oe;
        oe = idle_oe;
        unique case (st)
            ST_START: oe = (ph == Q3) ? 2'b11 : ((ph == Q2) ? 2'b10 : 2'b00);
            ST_BIT,
            ST_ACK:   oe = {bit_oe, (ph == Q0) || (ph == Q3)};
            ST_STOP:  oe = (ph == Q0) ? 2'b11 : ((ph == Q1) ? 2'b10 : 2'b00);
            default:  oe = idle_oe;
        endcase
        return oe;
    endfunction

endpackage

// File: rtl/nios_system_iic_if.sv
// Avalon-MM slave bundle of the I2C master: register access plus interrupt.
interface nios_system_iic_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
endinterface

// File: rtl/nios_system_iic_sync.sv
// Two-flop synchroniser for an open-drain bus line; resets to the idle-high level.
module nios_system_iic_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/nios_system_iic_master.sv
// Byte-level I2C master with Avalon-MM register file: START / byte write-read /
// ACK / STOP sequencing on open-drain SDA/SCL, clock stretching, completion irq.
module nios_system_iic_master
    import nios_system_iic_pkg::*;
#(
    parameter int unsigned      DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd124
) (
    input  logic              clk,
    input  logic              reset_n,
    nios_system_iic_if.slave  bus,
    inout  wire               sda_port,
    inout  wire               scl_port
);
    state_t           state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic [DIV_W-1:0] qcnt_q, qcnt_d, div_q, div_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d;
    logic [4:0]       cmd_q, cmd_d;
    logic             busy_q, busy_d, done_q, done_d, ien_q, ien_d, nack_q, nack_d;
    logic             sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             sda_s, scl_s, wr_en, hold_ph, stretch, bit_oe;
    logic             unused_wdata;

    nios_system_iic_sync u_sync_sda (.clk(clk), .reset_n(reset_n), .d(sda_port), .q(sda_s));
    nios_system_iic_sync u_sync_scl (.clk(clk), .reset_n(reset_n), .d(scl_port), .q(scl_s));

    assign sda_port     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl_port     = scl_oe_q ? 1'b0 : 1'bz;
    assign bus.readdata = readdata_q;
    assign bus.irq      = done_q & ien_q;
    assign unused_wdata = ^bus.writedata[31:DIV_W];

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        qcnt_d   = qcnt_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cmd_d    = cmd_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ien_d    = ien_q;
        nack_d   = nack_q;
        wr_en    = bus.chipselect && !bus.write_n;

        unique case (bus.address)
            ADDR_DATA:   readdata_d = {24'd0, rx_q};
            ADDR_STATUS: readdata_d = {28'd0, busy_q, ien_q, done_q, nack_q};
            ADDR_DIVIDER: readdata_d = 32'(div_q);
            default:     readdata_d = '0;
        endcase

        if (wr_en) begin
            unique case (bus.address)
                ADDR_DATA: if (!busy_q) tx_d = bus.writedata[7:0];
                ADDR_CMD: begin
                    if (!busy_q && (|bus.writedata[3:0])) begin
                        cmd_d = bus.writedata[4:0];
                        if (bus.writedata[CMD_WR]) cmd_d[CMD_RD] = 1'b0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        nack_d   = 1'b0;
                        ph_d     = Q0;
                        qcnt_d   = '0;
                        bitcnt_d = 3'd7;
                        if (bus.writedata[CMD_START])                            state_d = ST_START;
                        else if (bus.writedata[CMD_WR] || bus.writedata[CMD_RD]) state_d = ST_BIT;
                        else                                                     state_d = ST_STOP;
                    end
                end
                ADDR_STATUS: begin
                    ien_d = bus.writedata[STAT_IEN];
                    if (bus.writedata[STAT_DONE]) done_d = 1'b0;
                end
                default: if (!busy_q) div_d = bus.writedata[DIV_W-1:0];
            endcase
        end

        // SCL is checked one phase after its release, so synchroniser lag is
        // never mistaken for a stretching slave (assumes DIVIDER >= 1).
        hold_ph = ((state_q == ST_START) && (ph_q == Q1)) ||
                  (((state_q == ST_BIT) || (state_q == ST_ACK) || (state_q == ST_STOP)) && (ph_q == Q2));
        stretch = hold_ph && !scl_s;

        if ((state_q != ST_IDLE) && !stretch) begin
            if (qcnt_q != div_q) begin
                qcnt_d = qcnt_q + DIV_W'(1);
            end else begin
                qcnt_d = '0;
                if (ph_q == Q2) begin
                    if ((state_q == ST_BIT) && cmd_q[CMD_RD]) rx_d[bitcnt_q] = sda_s;
                    if ((state_q == ST_ACK) && cmd_q[CMD_WR]) nack_d = sda_s;
                end
                if (ph_q != Q3) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = Q0;
                    unique case (state_q)
                        ST_START: begin
                            if (cmd_q[CMD_WR] || cmd_q[CMD_RD]) state_d = ST_BIT;
                            else if (cmd_q[CMD_STOP])           state_d = ST_STOP;
                            else                                state_d = ST_IDLE;
                            bitcnt_d = 3'd7;
                        end
                        ST_BIT: begin
                            if (bitcnt_q == 3'd0) state_d = ST_ACK;
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                        ST_ACK:  state_d = cmd_q[CMD_STOP] ? ST_STOP : ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                    if (state_d == ST_IDLE) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
        end

        if (state_d == ST_BIT)      bit_oe = cmd_d[CMD_WR] & ~tx_q[bitcnt_d];
        else if (state_d == ST_ACK) bit_oe = cmd_d[CMD_RD] & ~cmd_d[CMD_ACKVAL];
        else                        bit_oe = 1'b0;
        {sda_oe_d, scl_oe_d} = line_drive(state_d, ph_d, bit_oe, {sda_oe_q, scl_oe_q});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= Q0;
            qcnt_q     <= '0;
            bitcnt_q   <= '0;
            div_q      <= DEFAULT_DIV;
            tx_q       <= '0;
            rx_q       <= '0;
            cmd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ien_q      <= 1'b0;
            nack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            qcnt_q     <= qcnt_d;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cmd_q      <= cmd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ien_q      <= ien_d;
            nack_q     <= nack_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            readdata_q <= readdata_d;
        end
    end
endmodule

// File: tb/tb_nios_system_iic_master.sv
// Directed bench for the I2C master: bus-level slave model (ACK, read data,
// clock stretch) with hand-computed register, bit and cycle-count expectations.
module tb_nios_system_iic_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    wire  sda_port, scl_port;
    logic slave_sda_oe = 1'b0;
    logic slave_scl_oe = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   rises = 0;
    int   falls = 0;
    logic [7:0] cap_byte = 8'h00;
    logic       cap_ack = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    logic       slave_rd = 1'b0;
    logic       slave_ack_en = 1'b0;
    logic       stretch_en = 1'b0;

    nios_system_iic_if bus ();

    nios_system_iic_master #(.DIV_W(16), .DEFAULT_DIV(16'd124)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .sda_port(sda_port), .scl_port(scl_port)
    );

    pullup (sda_port);
    pullup (scl_port);
    assign sda_port = slave_sda_oe ? 1'b0 : 1'bz;
    assign scl_port = slave_scl_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    // START condition restarts the slave's bit bookkeeping
    always @(negedge sda_port) if (scl_port === 1'b1) begin
        rises = 0;
        falls = 0;
    end

    always @(posedge scl_port) begin
        rises++;
        if (rises <= 8) cap_byte = {cap_byte[6:0], sda_port};
        else if (rises == 9) cap_ack = sda_port;
    end

    always @(negedge scl_port) begin
        falls++;
        if (slave_rd && falls >= 1 && falls <= 8) slave_sda_oe = ~slave_byte[8 - falls];
        else if (!slave_rd && slave_ack_en && falls == 9) slave_sda_oe = 1'b1;
        else slave_sda_oe = 1'b0;
        if (stretch_en && falls == 3) begin
            slave_scl_oe = 1'b1;
            repeat (24) @(posedge clk);
            #1 slave_scl_oe = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic clear_log();
        rises = 0; falls = 0; cap_byte = 8'h00; cap_ack = 1'b0;
        slave_sda_oe = 1'b0; slave_scl_oe = 1'b0;
    endtask

    // issue a command and count the cycles STATUS.busy reads 1
    task automatic run_cmd(input logic [31:0] c, output int busy_cycles);
        logic seen;
        busy_cycles = 0; seen = 1'b0;
        write_reg(2'd1, c);
        bus.address = 2'd2;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.readdata[3]) begin busy_cycles++; seen = 1'b1; end
            else if (seen) break;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int bc;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("idle_sda", {31'd0, sda_port}, 32'd1);
        check("idle_scl", {31'd0, scl_port}, 32'd1);
        read_reg(2'd2, rd); check("rst_status", rd, 32'h0);
        read_reg(2'd3, rd); check("rst_divider", rd, 32'd124);
        read_reg(2'd0, rd); check("rst_data", rd, 32'h0);

        // write 0xA5 with ACK, DIVIDER=1
        write_reg(2'd3, 32'd1);
        read_reg(2'd3, rd); check("div_set", rd, 32'd1);
        write_reg(2'd0, 32'hA5);
        clear_log(); slave_rd = 1'b0; slave_ack_en = 1'b1;
        run_cmd(32'h07, bc);
        check("wr_busy", bc, 32'd88);
        check("wr_bits", {24'd0, cap_byte}, 32'hA5);
        check("wr_ack_line", {31'd0, cap_ack}, 32'd0);
        read_reg(2'd2, rd); check("wr_status", rd, 32'h2);
        check("wr_irq_off", {31'd0, bus.irq}, 32'd0);

        // same byte, no ACK, interrupt enabled
        write_reg(2'd2, 32'h6);
        check("ien_irq0", {31'd0, bus.irq}, 32'd0);
        clear_log(); slave_ack_en = 1'b0;
        run_cmd(32'h07, bc);
        check("nack_busy", bc, 32'd88);
        read_reg(2'd2, rd); check("nack_status", rd, 32'h7);
        check("nack_irq", {31'd0, bus.irq}, 32'd1);
        write_reg(2'd2, 32'h6);
        check("irq_clear", {31'd0, bus.irq}, 32'd0);
        read_reg(2'd2, rd); check("nack_status2", rd, 32'h5);

        // read-only byte from idle bus, master ACKs
        write_reg(2'd2, 32'h2);
        clear_log(); slave_rd = 1'b1; slave_byte = 8'h3C;
        run_cmd(32'h08, bc);
        check("rd_busy", bc, 32'd72);
        read_reg(2'd0, rd); check("rd_data", rd, 32'h3C);
        check("rd_ack_low", {31'd0, cap_ack}, 32'd0);

        // repeated START + read + NACK + STOP
        clear_log(); slave_byte = 8'hC3;
        run_cmd(32'h1B, bc);
        check("rs_busy", bc, 32'd88);
        read_reg(2'd0, rd); check("rs_data", rd, 32'hC3);
        check("rs_nack_rel", {31'd0, cap_ack}, 32'd1);
        check("rs_sda_idle", {31'd0, sda_port}, 32'd1);
        check("rs_scl_idle", {31'd0, scl_port}, 32'd1);

        // clock stretching: SCL held 20 cycles longer than the master would
        clear_log(); slave_rd = 1'b0; slave_ack_en = 1'b1; stretch_en = 1'b1;
        run_cmd(32'h07, bc);
        stretch_en = 1'b0;
        check("st_busy", bc, 32'd108);
        check("st_bits", {24'd0, cap_byte}, 32'hA5);
        read_reg(2'd2, rd); check("st_status", rd, 32'h2);

        // register writes while busy are ignored
        clear_log();
        write_reg(2'd1, 32'h07);
        repeat (5) @(negedge clk);
        write_reg(2'd0, 32'hFF);
        write_reg(2'd1, 32'h0B);
        write_reg(2'd3, 32'd5);
        bus.address = 2'd2;
        bc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.readdata[3]) break;
            bc++;
        end
        check("ig_done_in_time", {31'd0, bc < 2999}, 32'd1);
        check("ig_bits", {24'd0, cap_byte}, 32'hA5);
        read_reg(2'd3, rd); check("ig_divider", rd, 32'd1);
        repeat (10) @(negedge clk);
        read_reg(2'd2, rd); check("ig_status", rd, 32'h2);

        // empty command: no activity, no irq
        write_reg(2'd2, 32'h6);
        write_reg(2'd1, 32'h00);
        repeat (5) @(negedge clk);
        read_reg(2'd2, rd); check("nop_status", rd, 32'h4);
        check("nop_irq", {31'd0, bus.irq}, 32'd0);

        // asynchronous reset in the middle of a byte
        clear_log(); slave_ack_en = 1'b1;
        write_reg(2'd1, 32'h07);
        for (int i = 0; i < 400 && falls < 3; i++) @(negedge clk);
        check("rst_wait", {31'd0, falls >= 3}, 32'd1);
        check("mid_scl_low", {31'd0, scl_port}, 32'd0);
        check("mid_sda_low", {31'd0, sda_port}, 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_sda_rel", {31'd0, sda_port}, 32'd1);
        check("rst_scl_rel", {31'd0, scl_port}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        read_reg(2'd2, rd); check("rst2_status", rd, 32'h0);
        read_reg(2'd3, rd); check("rst2_divider", rd, 32'd124);
        read_reg(2'd0, rd); check("rst2_data", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
